decode_stage: RTL
=================

# decode_stage

Second stage of the five-stage RV32I pipeline. It sits directly downstream of the fetch stage and consumes its InstrD/PCD/PCPlus4D outputs. It holds the 32x32 register file, decodes control, and sign-extends immediates. All results are registered into the decode-to-execute pipeline register for the execute stage. It also exports source-register indices to the hazard unit and accepts the writeback port from the final stage.

## Interface
- `WORD_SIZE`, 32 (from shared constants): datapath width.
- `REG_ADDR`, 5: register index width.
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-low (asserted when 0).
- InstrD  in  32  instruction from fetch stage.
- PCD, PCPlus4D  in  32 each  PC and PC+4 from fetch stage.
- FlushE  in  1  hazard unit: turn next E-register contents into a bubble.
- RegWriteW  in  1  writeback enable.
- RdW  in  5  writeback destination.
- ResultW  in  32  writeback data.
- Rs1D, Rs2D  out  5 each  combinational source indices for the hazard unit: InstrD[19:15] and InstrD[24:20].
- RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE  out  1 each  registered control.
- ResultSrcE  out  2  00 ALU, 01 memory, 10 PC+4.
- ALUControlE  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt.
- RD1E, RD2E, ImmExtE, PCE, PCPlus4E  out  32 each  registered data.
- Rs1E, Rs2E, RdE  out  5 each  registered register indices.

## Operation
- Opcodes decoded:
  - 0000011 lw
  - 0100011 sw
  - 0110011 R-type
  - 0010011 I-ALU
  - 1100011 beq
  - 1101111 jal
- Any other opcode, including InstrD = 0, decodes to all-zero control. That is a bubble, with no register write and no memory write.
- ALU decode for R-type and I-ALU, using funct3 and funct7[5]:
  - add/addi -> 000.
  - sub (R-type only, funct7[5] = 1) -> 001.
  - slt/slti -> 101.
  - or/ori -> 011.
  - and/andi -> 010.
  - Any other funct3 -> 000.
- ALU decode for other opcodes: lw and sw use add; beq uses sub.
- Immediate forms:
  - I-type for lw and I-ALU.
  - S-type for sw.
  - B-type for beq.
  - J-type for jal.
  - All forms are sign-extended from InstrD[31] to 32 bits. Undecoded opcodes give ImmExt = 0.
- Register file:
  - 32 entries of 32 bits.
  - x0 reads 0 always; writes to x0 are ignored.
  - Two combinational read ports and one synchronous write port.
- Write-through bypass: if RegWriteW=1, RdW≠0 and RdW equals a read index, that read port returns ResultW in the same cycle. This resolves the W/D same-cycle hazard.
- E register priority per rising edge: reset > FlushE > load.
  - Reset: clears every E output and every register-file entry to 0.
  - FlushE: clears every E output to 0. The register-file write still occurs.
  - Load: captures decoded control, read data, immediate, indices and PCs.
- No stall input: the E register updates every cycle.

## Timing
- Latency is one cycle. Fields decoded from InstrD in cycle n appear on the E outputs after the rising edge that ends cycle n.
- Rs1D and Rs2D are combinational from InstrD with zero latency.
- A register-file write commits at the same edge that loads the E register. Because of the bypass, the value is visible to a read in the cycle the write is presented.
- Reset asserted mid-stream, for a single cycle, produces all-zero E outputs and a zeroed register file at that edge. The first instruction after release decodes normally.
- FlushE together with RegWriteW: the E register becomes a bubble and the write is still committed.

## Structure
- Shared package/constants:
  - WORD_SIZE.
  - Opcode constants.
  - ALUControl encodings.
  - ResultSrc encodings.
  - ImmSrc encoding (00 I, 01 S, 10 B, 11 J).
- Sub-modules:
  - `register_file`: storage, x0 rule, bypass, synchronous active-low clear.
  - Control decode and immediate extension stay inline in decode_stage.

## Test plan
- Reset with rst=0 for 2 cycles -> all E outputs 0. Then a read of every register returns 0.
- InstrD=0x00700293 (addi x5,x0,7) -> next edge:
  - RegWriteE=1, ALUSrcE=1, ALUControlE=000, ResultSrcE=00.
  - ImmExtE=7, RdE=5, Rs1E=0, RD1E=0.
- RegWriteW=1, RdW=5, ResultW=7 while InstrD=0x0082A303 (lw x6,8(x5)) -> next edge:
  - RD1E=7 via bypass, ImmExtE=8, ResultSrcE=01, RdE=6, RegWriteE=1.
  - The following cycle a read of x5 returns 7 from storage.
- InstrD=0xFE000EE3 (beq x0,x0,-4), PCD=0x20 -> BranchE=1, ALUControlE=001, ImmExtE=0xFFFFFFFC, PCE=0x20, RegWriteE=0.
- FlushE=1 with a valid sw instruction on InstrD -> MemWriteE=0 and all E outputs 0. A concurrent write of x7 with RegWriteW=1 still lands in the register file.
- RegWriteW=1, RdW=0, ResultW=0xDEADBEEF -> reads of x0 return 0 in the same cycle and in later cycles. An undecoded opcode (0x0000007F) -> all-zero control.

Source files
------------

// File: rtl/decode_stage_pkg.sv
// Shared constants, encodings and helper types for the RV32I decode stage.
package decode_stage_pkg;

    localparam int unsigned WORD_SIZE = 32;
    localparam int unsigned REG_ADDR  = 5;
    localparam int unsigned NUM_REGS  = 32;

    // Major opcodes understood by the decoder; everything else is a bubble.
    typedef enum logic [6:0] {
        OP_LW    = 7'b0000011,
        OP_SW    = 7'b0100011,
        OP_RTYPE = 7'b0110011,
        OP_IALU  = 7'b0010011,
        OP_BEQ   = 7'b1100011,
        OP_JAL   = 7'b1101111
    } opcode_t;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_ctrl_t;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_t;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } imm_src_t;

    // Control bundle carried into the execute stage.
    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic       jump;
        logic       branch;
        logic       alu_src;
        logic [1:0] result_src;
        logic [2:0] alu_control;
    } ctrl_t;

    // Full decode-to-execute pipeline register image.
    typedef struct packed {
        ctrl_t                 ctrl;
        logic [WORD_SIZE-1:0]  rd1;
        logic [WORD_SIZE-1:0]  rd2;
        logic [WORD_SIZE-1:0]  imm_ext;
        logic [WORD_SIZE-1:0]  pc;
        logic [WORD_SIZE-1:0]  pc_plus4;
        logic [REG_ADDR-1:0]   rs1;
        logic [REG_ADDR-1:0]   rs2;
        logic [REG_ADDR-1:0]   rd;
    } e_reg_t;

    // Assemble and sign-extend the immediate for the given format.
    function automatic logic [WORD_SIZE-1:0] imm_extend(
        input logic [WORD_SIZE-1:0] instr,
        input imm_src_t             src
    );
        logic [WORD_SIZE-1:0] imm;
        imm = '0;
        case (src)
            IMM_I: imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S: imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B: imm = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_J: imm = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = '0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Bus between fetch/hazard/writeback logic and the decode stage.
interface decode_stage_if;
    import decode_stage_pkg::*;

    // Fetch side
    logic [WORD_SIZE-1:0] InstrD;
    logic [WORD_SIZE-1:0] PCD;
    logic [WORD_SIZE-1:0] PCPlus4D;
    // Hazard unit
    logic                 FlushE;
    logic [REG_ADDR-1:0]  Rs1D;
    logic [REG_ADDR-1:0]  Rs2D;
    // Writeback port
    logic                 RegWriteW;
    logic [REG_ADDR-1:0]  RdW;
    logic [WORD_SIZE-1:0] ResultW;
    // Execute-stage register outputs
    logic                 RegWriteE;
    logic                 MemWriteE;
    logic                 JumpE;
    logic                 BranchE;
    logic                 ALUSrcE;
    logic [1:0]           ResultSrcE;
    logic [2:0]           ALUControlE;
    logic [WORD_SIZE-1:0] RD1E;
    logic [WORD_SIZE-1:0] RD2E;
    logic [WORD_SIZE-1:0] ImmExtE;
    logic [WORD_SIZE-1:0] PCE;
    logic [WORD_SIZE-1:0] PCPlus4E;
    logic [REG_ADDR-1:0]  Rs1E;
    logic [REG_ADDR-1:0]  Rs2E;
    logic [REG_ADDR-1:0]  RdE;

    modport master (
        output InstrD, PCD, PCPlus4D, FlushE, RegWriteW, RdW, ResultW,
        input  Rs1D, Rs2D,
        input  RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE, ALUControlE,
        input  RD1E, RD2E, ImmExtE, PCE, PCPlus4E, Rs1E, Rs2E, RdE
    );

    modport slave (
        input  InstrD, PCD, PCPlus4D, FlushE, RegWriteW, RdW, ResultW,
        output Rs1D, Rs2D,
        output RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE, ALUControlE,
        output RD1E, RD2E, ImmExtE, PCE, PCPlus4E, Rs1E, Rs2E, RdE
    );

endinterface

// File: rtl/decode_stage_register_file.sv
// 32x32 register file: x0 hard-wired to zero, two async reads with
// write-through bypass, one synchronous write, synchronous active-low clear.
module register_file
    import decode_stage_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_we,
    input  logic [REG_ADDR-1:0]  i_wa,
    input  logic [WORD_SIZE-1:0] i_wd,
    input  logic [REG_ADDR-1:0]  i_ra1,
    input  logic [REG_ADDR-1:0]  i_ra2,
    output logic [WORD_SIZE-1:0] o_rd1,
    output logic [WORD_SIZE-1:0] o_rd2
);

    logic [WORD_SIZE-1:0] r_mem [NUM_REGS];
    logic                 w_wr_valid;

    assign w_wr_valid = i_we && (i_wa != '0);

    // Storage update: clear everything on reset, otherwise commit the write.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_valid) begin
            r_mem[i_wa] <= i_wd;
        end
    end

    // Read ports: x0 is zero, a same-cycle write to the index is forwarded.
    always_comb begin
        o_rd1 = '0;
        o_rd2 = '0;
        if (i_ra1 == '0) begin
            o_rd1 = '0;
        end else if (w_wr_valid && (i_wa == i_ra1)) begin
            o_rd1 = i_wd;
        end else begin
            o_rd1 = r_mem[i_ra1];
        end
        if (i_ra2 == '0) begin
            o_rd2 = '0;
        end else if (w_wr_valid && (i_wa == i_ra2)) begin
            o_rd2 = i_wd;
        end else begin
            o_rd2 = r_mem[i_ra2];
        end
    end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: control decode, immediate extension, register file
// and the decode-to-execute pipeline register.
module decode_stage
    import decode_stage_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    decode_stage_if.slave  if_d
);

    logic [6:0]           w_opcode;
    logic [2:0]           w_funct3;
    logic                 w_funct7_5;
    logic [REG_ADDR-1:0]  w_rs1;
    logic [REG_ADDR-1:0]  w_rs2;
    logic [REG_ADDR-1:0]  w_rd;
    logic [2:0]           w_alu_funct;
    ctrl_t                w_ctrl;
    imm_src_t             w_imm_src;
    logic                 w_imm_valid;
    logic [WORD_SIZE-1:0] w_imm;
    logic [WORD_SIZE-1:0] w_rd1;
    logic [WORD_SIZE-1:0] w_rd2;
    e_reg_t               r_e;

    assign w_opcode   = if_d.InstrD[6:0];
    assign w_rd       = if_d.InstrD[11:7];
    assign w_funct3   = if_d.InstrD[14:12];
    assign w_rs1      = if_d.InstrD[19:15];
    assign w_rs2      = if_d.InstrD[24:20];
    assign w_funct7_5 = if_d.InstrD[30];

    assign if_d.Rs1D  = w_rs1;
    assign if_d.Rs2D  = w_rs2;

    register_file u_register_file (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_we    (if_d.RegWriteW),
        .i_wa    (if_d.RdW),
        .i_wd    (if_d.ResultW),
        .i_ra1   (w_rs1),
        .i_ra2   (w_rs2),
        .o_rd1   (w_rd1),
        .o_rd2   (w_rd2)
    );

    // ALU operation from funct3/funct7; subtract only exists for R-type.
    always_comb begin
        w_alu_funct = ALU_ADD;
        case (w_funct3)
            3'b000:  w_alu_funct = ((w_opcode == OP_RTYPE) && w_funct7_5) ? ALU_SUB : ALU_ADD;
            3'b010:  w_alu_funct = ALU_SLT;
            3'b110:  w_alu_funct = ALU_OR;
            3'b111:  w_alu_funct = ALU_AND;
            default: w_alu_funct = ALU_ADD;
        endcase
    end

    // Main control decode; unknown opcodes leave everything zero (bubble).
    always_comb begin
        w_ctrl      = '0;
        w_imm_src   = IMM_I;
        w_imm_valid = 1'b0;
        case (w_opcode)
            OP_LW: begin
                w_ctrl.reg_write   = 1'b1;
                w_ctrl.alu_src     = 1'b1;
                w_ctrl.result_src  = RES_MEM;
                w_ctrl.alu_control = ALU_ADD;
                w_imm_src          = IMM_I;
                w_imm_valid        = 1'b1;
            end
            OP_SW: begin
                w_ctrl.mem_write   = 1'b1;
                w_ctrl.alu_src     = 1'b1;
                w_ctrl.alu_control = ALU_ADD;
                w_imm_src          = IMM_S;
                w_imm_valid        = 1'b1;
            end
            OP_RTYPE: begin
                w_ctrl.reg_write   = 1'b1;
                w_ctrl.alu_control = w_alu_funct;
            end
            OP_IALU: begin
                w_ctrl.reg_write   = 1'b1;
                w_ctrl.alu_src     = 1'b1;
                w_ctrl.alu_control = w_alu_funct;
                w_imm_src          = IMM_I;
                w_imm_valid        = 1'b1;
            end
            OP_BEQ: begin
                w_ctrl.branch      = 1'b1;
                w_ctrl.alu_control = ALU_SUB;
                w_imm_src          = IMM_B;
                w_imm_valid        = 1'b1;
            end
            OP_JAL: begin
                w_ctrl.reg_write   = 1'b1;
                w_ctrl.jump        = 1'b1;
                w_ctrl.result_src  = RES_PC4;
                w_ctrl.alu_control = ALU_ADD;
                w_imm_src          = IMM_J;
                w_imm_valid        = 1'b1;
            end
            default: ;
        endcase
    end

    assign w_imm = w_imm_valid ? imm_extend(if_d.InstrD, w_imm_src) : '0;

    // Execute-stage register: reset and flush both produce a bubble.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_e <= '0;
        end else if (if_d.FlushE) begin
            r_e <= '0;
        end else begin
            r_e.ctrl     <= w_ctrl;
            r_e.rd1      <= w_rd1;
            r_e.rd2      <= w_rd2;
            r_e.imm_ext  <= w_imm;
            r_e.pc       <= if_d.PCD;
            r_e.pc_plus4 <= if_d.PCPlus4D;
            r_e.rs1      <= w_rs1;
            r_e.rs2      <= w_rs2;
            r_e.rd       <= w_rd;
        end
    end

    assign if_d.RegWriteE   = r_e.ctrl.reg_write;
    assign if_d.MemWriteE   = r_e.ctrl.mem_write;
    assign if_d.JumpE       = r_e.ctrl.jump;
    assign if_d.BranchE     = r_e.ctrl.branch;
    assign if_d.ALUSrcE     = r_e.ctrl.alu_src;
    assign if_d.ResultSrcE  = r_e.ctrl.result_src;
    assign if_d.ALUControlE = r_e.ctrl.alu_control;
    assign if_d.RD1E        = r_e.rd1;
    assign if_d.RD2E        = r_e.rd2;
    assign if_d.ImmExtE     = r_e.imm_ext;
    assign if_d.PCE         = r_e.pc;
    assign if_d.PCPlus4E    = r_e.pc_plus4;
    assign if_d.Rs1E        = r_e.rs1;
    assign if_d.Rs2E        = r_e.rs2;
    assign if_d.RdE         = r_e.rd;

endmodule
